n64_vdemux: RTL and testbench



---
 rtl/n64_vdemux.sv | 140 ++++++++++++++
 tb/tb_n64_vdemux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vdemux.sv
// n64_vdemux: splits the multiplexed N64 video bus into one parallel
// sync+RGB word per pixel group.
// A group is a sync nibble (nDSYNC low) followed by the R, G and B phases.
// A complete group is published one edge after its blue phase.
// Malformed groups are dropped, and the output keeps the last complete word.
// Optional feature macro: VDEMUX_ERRCNT_EN adds a saturating 8-bit counter of
// malformed-group events. When it is undefined, err_cnt_o is tied to zero.
module n64_vdemux #(
  parameter int color_width_i = 7,
  localparam int vdata_width_i = 3 * color_width_i + 4
) (
  input  logic                     VCLK,
  input  logic                     VRST,
  input  logic                     nDSYNC,
  input  logic [color_width_i-1:0] D_i,
  output logic [vdata_width_i-1:0] video_data_o,
  output logic                     nVDSYNC_o,
  output logic [7:0]               err_cnt_o
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PH_R = 2'd1,
    ST_PH_G = 2'd2,
    ST_PH_B = 2'd3
  } state_t;

  // Idle word: sync lines inactive (high), colours black.
  localparam logic [vdata_width_i-1:0] VDATA_RST = {4'hF, {(3 * color_width_i){1'b0}}};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_publish;
  logic                     w_publish_nxt;
  logic                     w_cap_sync;
  logic                     w_cap_r;
  logic                     w_cap_g;
  logic                     w_cap_b;
  logic [3:0]               r_sync;
  logic [color_width_i-1:0] r_red;
  logic [color_width_i-1:0] r_grn;
  logic [color_width_i-1:0] r_blu;
  logic [vdata_width_i-1:0] r_video_data;
  logic                     r_nvdsync;

  // Phase sequencing: a sync always restarts the group; colour phases advance in order.
  always_comb begin
    w_state_nxt   = r_state;
    w_publish_nxt = 1'b0;
    w_cap_sync    = 1'b0;
    w_cap_r       = 1'b0;
    w_cap_g       = 1'b0;
    w_cap_b       = 1'b0;
    if (!nDSYNC) begin
      w_cap_sync  = 1'b1;
      w_state_nxt = ST_PH_R;
    end else begin
      case (r_state)
        ST_WAIT: begin
          w_state_nxt = ST_WAIT;
        end
        ST_PH_R: begin
          w_cap_r     = 1'b1;
          w_state_nxt = ST_PH_G;
        end
        ST_PH_G: begin
          w_cap_g     = 1'b1;
          w_state_nxt = ST_PH_B;
        end
        ST_PH_B: begin
          w_cap_b       = 1'b1;
          w_publish_nxt = 1'b1;
          w_state_nxt   = ST_WAIT;
        end
        default: begin
          w_state_nxt = ST_WAIT;
        end
      endcase
    end
  end

  // State, shadow capture and publication of the completed group.
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      r_state      <= ST_WAIT;
      r_publish    <= 1'b0;
      r_sync       <= 4'hF;
      r_red        <= '0;
      r_grn        <= '0;
      r_blu        <= '0;
      r_video_data <= VDATA_RST;
      r_nvdsync    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_publish <= w_publish_nxt;
      if (w_cap_sync) r_sync <= D_i[3:0];
      if (w_cap_r)    r_red  <= D_i;
      if (w_cap_g)    r_grn  <= D_i;
      if (w_cap_b)    r_blu  <= D_i;
      if (r_publish) begin
        r_video_data <= {r_sync, r_red, r_grn, r_blu};
        r_nvdsync    <= 1'b0;
      end else begin
        r_nvdsync    <= 1'b1;
      end
    end
  end

  assign video_data_o = r_video_data;
  assign nVDSYNC_o    = r_nvdsync;

`ifdef VDEMUX_ERRCNT_EN
  logic       w_err_evt;
  logic [7:0] r_err_cnt;

  // Error event: sync cutting a group short, or no sync right after a completed group.
  always_comb begin
    w_err_evt = 1'b0;
    if (!nDSYNC) begin
      w_err_evt = (r_state != ST_WAIT);
    end else begin
      w_err_evt = (r_state == ST_WAIT) && r_publish;
    end
  end

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_n64_vdemux.sv
// Self-checking bench for n64_vdemux.
// Each scenario task pushes expected words when it drives a blue phase.
// A monitor forked from the main initial block pops and compares them when
// nVDSYNC_o goes low.
module tb_n64_vdemux;

  logic        VCLK = 1'b0;
  logic        VRST = 1'b1;
  logic        nDSYNC = 1'b1;
  logic [6:0]  D_i = 7'h00;
  logic [24:0] video_data_o;
  logic        nVDSYNC_o;
  logic [7:0]  err_cnt_o;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [24:0] exp_q[$];
  int          pub_cyc[$];

  localparam logic [24:0] VRST_WORD = 25'h1E00000;

  n64_vdemux dut (
    .VCLK         (VCLK),
    .VRST         (VRST),
    .nDSYNC       (nDSYNC),
    .D_i          (D_i),
    .video_data_o (video_data_o),
    .nVDSYNC_o    (nVDSYNC_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 VCLK = ~VCLK;

  function automatic logic [7:0] exp_err(int n);
`ifdef VDEMUX_ERRCNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  // Drive one bus cycle (called at posedge+1), then return 1 time unit after the sampling edge.
  task automatic send(input logic rst, input logic nd, input logic [6:0] d);
    VRST   = rst;
    nDSYNC = nd;
    D_i    = d;
    @(posedge VCLK);
    #1;
  endtask

  task automatic do_reset();
    VRST   = 1'b1;
    nDSYNC = 1'b1;
    D_i    = 7'h00;
    repeat (2) @(posedge VCLK);
    #1;
    VRST = 1'b0;
  endtask

  task automatic monitor_loop();
    logic        prev_low = 1'b0;
    int          cyc = 0;
    logic [24:0] w;
    forever begin
      @(negedge VCLK);
      cyc++;
      if (nVDSYNC_o === 1'b0) begin
        n_checks++;
        if (prev_low) $display("FAIL nvdsync_consecutive: low on two cycles at cycle %0d", cyc);
        else n_pass++;
        pub_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_publish: got %h, expected no publish", video_data_o);
        end else begin
          w = exp_q.pop_front();
          if (video_data_o !== w) $display("FAIL publish_word: got %h expected %h", video_data_o, w);
          else n_pass++;
        end
      end
      prev_low = (nVDSYNC_o === 1'b0);
    end
  endtask

  task automatic check_drained(input string name);
    @(negedge VCLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drained: %0d pending, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (video_data_o !== VRST_WORD) $display("FAIL reset_video: got %h expected %h", video_data_o, VRST_WORD);
    else n_pass++;
    n_checks++;
    if (nVDSYNC_o !== 1'b1) $display("FAIL reset_nvdsync: got %b expected 1", nVDSYNC_o);
    else n_pass++;
    n_checks++;
    if (err_cnt_o !== 8'h00) $display("FAIL reset_err: got %h expected 00", err_cnt_o);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [24:0] w1;
    logic [24:0] w2;
    w1 = {4'hF, 7'h11, 7'h22, 7'h33};
    w2 = {4'h3, 7'h01, 7'h02, 7'h03};
    do_reset();
    send(1'b0, 1'b0, 7'h0F);
    send(1'b0, 1'b1, 7'h11);
    send(1'b0, 1'b1, 7'h22);
    exp_q.push_back(w1);
    send(1'b0, 1'b1, 7'h33);
    n_checks++;
    if (nVDSYNC_o !== 1'b1 || video_data_o !== VRST_WORD)
      $display("FAIL basic_early: nvdsync %b video %h, expected 1 %h", nVDSYNC_o, video_data_o, VRST_WORD);
    else n_pass++;
    send(1'b0, 1'b0, 7'h03);
    n_checks++;
    if (nVDSYNC_o !== 1'b0 || video_data_o !== w1)
      $display("FAIL basic_publish: nvdsync %b video %h, expected 0 %h", nVDSYNC_o, video_data_o, w1);
    else n_pass++;
    n_checks++;
    if (err_cnt_o !== exp_err(0)) $display("FAIL basic_err: got %h expected %h", err_cnt_o, exp_err(0));
    else n_pass++;
    send(1'b0, 1'b1, 7'h01);
    n_checks++;
    if (nVDSYNC_o !== 1'b1 || video_data_o !== w1)
      $display("FAIL basic_pulse_width: nvdsync %b video %h, expected 1 %h", nVDSYNC_o, video_data_o, w1);
    else n_pass++;
    send(1'b0, 1'b1, 7'h02);
    exp_q.push_back(w2);
    send(1'b0, 1'b1, 7'h03);
    send(1'b0, 1'b1, 7'h00);
    n_checks++;
    if (video_data_o !== w2 || err_cnt_o !== exp_err(1))
      $display("FAIL basic_second: video %h err %h, expected %h %h", video_data_o, err_cnt_o, w2, exp_err(1));
    else n_pass++;
    check_drained("basic");
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = pub_cyc.size();
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0, {3'b101, 4'(i)});
      send(1'b0, 1'b1, 7'(i));
      send(1'b0, 1'b1, 7'(i + 40));
      exp_q.push_back({4'(i), 7'(i), 7'(i + 40), 7'(i + 80)});
      send(1'b0, 1'b1, 7'(i + 80));
    end
    send(1'b0, 1'b0, 7'h00);
    n_checks++;
    if (err_cnt_o !== exp_err(0)) $display("FAIL b2b_err: got %h expected %h", err_cnt_o, exp_err(0));
    else n_pass++;
    check_drained("b2b");
    n_checks++;
    if (pub_cyc.size() - base != 100) $display("FAIL b2b_count: got %0d expected 100", pub_cyc.size() - base);
    else n_pass++;
    for (int i = base + 1; i < pub_cyc.size(); i++) begin
      n_checks++;
      if (pub_cyc[i] - pub_cyc[i-1] != 4)
        $display("FAIL b2b_spacing: got %0d cycles expected 4 (publish %0d)", pub_cyc[i] - pub_cyc[i-1], i - base);
      else n_pass++;
    end
  endtask

  task automatic test_drop();
    logic [24:0] w;
    w = {4'h5, 7'h10, 7'h01, 7'h02};
    do_reset();
    send(1'b0, 1'b0, 7'h0A);
    send(1'b0, 1'b1, 7'h7F);
    send(1'b0, 1'b0, 7'h05);
    send(1'b0, 1'b1, 7'h10);
    send(1'b0, 1'b1, 7'h01);
    exp_q.push_back(w);
    send(1'b0, 1'b1, 7'h02);
    send(1'b0, 1'b0, 7'h00);
    n_checks++;
    if (nVDSYNC_o !== 1'b0 || video_data_o !== w)
      $display("FAIL drop_publish: nvdsync %b video %h, expected 0 %h", nVDSYNC_o, video_data_o, w);
    else n_pass++;
    n_checks++;
    if (err_cnt_o !== exp_err(1)) $display("FAIL drop_err: got %h expected %h", err_cnt_o, exp_err(1));
    else n_pass++;
    check_drained("drop");
  endtask

  task automatic test_missed_sync();
    logic [24:0] w;
    w = {4'hC, 7'h21, 7'h42, 7'h63};
    do_reset();
    send(1'b0, 1'b0, 7'h0C);
    send(1'b0, 1'b1, 7'h21);
    send(1'b0, 1'b1, 7'h42);
    exp_q.push_back(w);
    send(1'b0, 1'b1, 7'h63);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1, 7'h00);
    n_checks++;
    if (err_cnt_o !== exp_err(1)) $display("FAIL missed_err: got %h expected %h", err_cnt_o, exp_err(1));
    else n_pass++;
    n_checks++;
    if (video_data_o !== w || nVDSYNC_o !== 1'b1)
      $display("FAIL missed_hold: video %h nvdsync %b, expected %h 1", video_data_o, nVDSYNC_o, w);
    else n_pass++;
    check_drained("missed");
  endtask

  task automatic test_saturate();
    logic [24:0] w;
    w = {4'hF, 7'h11, 7'h22, 7'h33};
    do_reset();
    for (int i = 0; i <= 300; i++) begin
      send(1'b0, 1'b0, 7'h0F);
      if (i == 100) begin
        n_checks++;
        if (err_cnt_o !== exp_err(100)) $display("FAIL sat_mid_err: got %h expected %h", err_cnt_o, exp_err(100));
        else n_pass++;
      end
    end
    n_checks++;
    if (err_cnt_o !== exp_err(300)) $display("FAIL sat_err: got %h expected %h", err_cnt_o, exp_err(300));
    else n_pass++;
    send(1'b0, 1'b1, 7'h11);
    send(1'b0, 1'b1, 7'h22);
    exp_q.push_back(w);
    send(1'b0, 1'b1, 7'h33);
    send(1'b0, 1'b0, 7'h00);
    n_checks++;
    if (video_data_o !== w || err_cnt_o !== exp_err(300))
      $display("FAIL sat_publish: video %h err %h, expected %h %h", video_data_o, err_cnt_o, w, exp_err(300));
    else n_pass++;
    check_drained("sat");
  endtask

  task automatic test_reset_mid_group();
    logic [24:0] w1;
    logic [24:0] w3;
    w1 = {4'h3, 7'h15, 7'h2A, 7'h3F};
    w3 = {4'h6, 7'h01, 7'h02, 7'h03};
    do_reset();
    send(1'b0, 1'b0, 7'h03);
    send(1'b0, 1'b1, 7'h15);
    send(1'b0, 1'b1, 7'h2A);
    exp_q.push_back(w1);
    send(1'b0, 1'b1, 7'h3F);
    send(1'b0, 1'b0, 7'h09);
    send(1'b0, 1'b1, 7'h44);
    send(1'b0, 1'b1, 7'h55);
    send(1'b1, 1'b1, 7'h66);
    n_checks++;
    if (video_data_o !== VRST_WORD || nVDSYNC_o !== 1'b1 || err_cnt_o !== 8'h00)
      $display("FAIL rstmid_values: video %h nvdsync %b err %h, expected %h 1 00",
               video_data_o, nVDSYNC_o, err_cnt_o, VRST_WORD);
    else n_pass++;
    send(1'b0, 1'b1, 7'h00);
    n_checks++;
    if (nVDSYNC_o !== 1'b1 || video_data_o !== VRST_WORD)
      $display("FAIL rstmid_no_publish: nvdsync %b video %h, expected 1 %h", nVDSYNC_o, video_data_o, VRST_WORD);
    else n_pass++;
    send(1'b0, 1'b0, 7'h06);
    send(1'b0, 1'b1, 7'h01);
    send(1'b0, 1'b1, 7'h02);
    exp_q.push_back(w3);
    send(1'b0, 1'b1, 7'h03);
    send(1'b0, 1'b0, 7'h00);
    n_checks++;
    if (nVDSYNC_o !== 1'b0 || video_data_o !== w3)
      $display("FAIL rstmid_after: nvdsync %b video %h, expected 0 %h", nVDSYNC_o, video_data_o, w3);
    else n_pass++;
    check_drained("rstmid");
  endtask

  // Scenario sequence with the publish monitor running alongside.
  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_missed_sync();
    test_saturate();
    test_reset_mid_group();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
